// File: rtl/hm_pkg.sv
// -----------------------------------------------------------------------------
// hm_pkg
//  Shared types and constants for the nonce sweep controller.
//  - sweep_state_t : controller FSM encoding
//  - nonce_t       : default-width nonce
//  - DEFAULT_TIMEOUT : default hasher response limit in cycles
// -----------------------------------------------------------------------------
package hm_pkg;

   localparam int NONCE_BITS      = 32;
   localparam int DEFAULT_TIMEOUT = 1024;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      FOUND,
      EXHAUSTED,
      ERROR
   } sweep_state_t;

   typedef logic [NONCE_BITS-1:0] nonce_t;

endpackage

// File: rtl/hm_sat_counter.sv
// -----------------------------------------------------------------------------
// hm_sat_counter
//  Up-counter that sticks at all-ones instead of wrapping.
//  Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high (count -> 0)
//   clr   in   synchronous clear (count -> 0), wins over inc
//   inc   in   advance count by one unless saturated
//   count out  current count
// -----------------------------------------------------------------------------
module hm_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/hm_nonce_sweep.sv
// -----------------------------------------------------------------------------
// hm_nonce_sweep
//  Nonce sweep controller: walks a nonce range one hash job at a time, stops
//  on the first hash the comparator flags as valid and holds the winning
//  nonce/hash until the host acknowledges it.
//  Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             pulse: begin a sweep (IDLE/EXHAUSTED/ERROR only)
//   abort             level: drop back to IDLE, wins over everything else
//   nonce_first/last  inclusive range, sampled on an accepted start
//   hash_done         hasher job finished (1-cycle pulse)
//   valid_hash_flag   comparator result, qualified by hash_done
//   out_hash          hasher result, qualified by hash_done
//   result_ack        host consumed the found result
//   hash_start        1-cycle pulse launching the hasher on cur_nonce
//   cur_nonce         nonce presented to the hasher
//   busy              sweep in progress
//   found             winning nonce/hash held
//   found_nonce/hash  captured winner
//   exhausted         range finished without a hit
//   timeout_err       hasher did not answer in time
//   hash_count        hashes completed this sweep (saturating)
// -----------------------------------------------------------------------------
module hm_nonce_sweep
   import hm_pkg::*;
#(
   parameter int NONCE_W = 32,
   parameter int HASH_W  = 256,
   parameter int COUNT_W = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [NONCE_W-1:0] nonce_first,
   input  logic [NONCE_W-1:0] nonce_last,
   input  logic               hash_done,
   input  logic               valid_hash_flag,
   input  logic [HASH_W-1:0]  out_hash,
   input  logic               result_ack,
   output logic               hash_start,
   output logic [NONCE_W-1:0] cur_nonce,
   output logic               busy,
   output logic               found,
   output logic [NONCE_W-1:0] found_nonce,
   output logic [HASH_W-1:0]  found_hash,
   output logic               exhausted,
   output logic               timeout_err,
   output logic [COUNT_W-1:0] hash_count
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   sweep_state_t       state;
   sweep_state_t       state_nxt;
   logic [NONCE_W-1:0] last_nonce;
   logic [TMO_W-1:0]   tmo_count;

   logic start_ok;   // start accepted this cycle
   logic job_done;   // hasher result counted this cycle
   logic tmo_hit;

   // abort overrides start even in IDLE, so an accepted start needs !abort.
   assign start_ok = start && !abort &&
                     (state inside {IDLE, EXHAUSTED, ERROR});
   assign job_done = (state == WAIT) && hash_done && !abort;
   assign tmo_hit  = (tmo_count == TMO_W'(TIMEOUT - 1));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   // NOTE: state_nxt takes a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE, EXHAUSTED, ERROR: if (start) state_nxt = LAUNCH;
            LAUNCH:                 state_nxt = WAIT;
            WAIT: begin
               if (hash_done) begin
                  if (valid_hash_flag)               state_nxt = FOUND;
                  else if (cur_nonce == last_nonce)  state_nxt = EXHAUSTED;
                  else                               state_nxt = LAUNCH;
               end else if (tmo_hit) begin
                  state_nxt = ERROR;
               end
            end
            FOUND:   if (result_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------ outputs
   // Pure decodes of the state flop: no input-to-output path.
   always_comb begin
      hash_start  = (state == LAUNCH);
      busy        = (state == LAUNCH) || (state == WAIT);
      found       = (state == FOUND);
      exhausted   = (state == EXHAUSTED);
      timeout_err = (state == ERROR);
   end

   // ---------------------------------------------------------------- datapath
   // NOTE: the wide result registers are reset too, since every output must
   // read zero after reset rather than holding a stale winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_nonce   <= '0;
         last_nonce  <= '0;
         found_nonce <= '0;
         found_hash  <= '0;
      end else if (start_ok) begin
         cur_nonce  <= nonce_first;
         last_nonce <= nonce_last;
      end else if (job_done) begin
         if (valid_hash_flag) begin
            found_nonce <= cur_nonce;
            found_hash  <= out_hash;
         end else if (cur_nonce != last_nonce) begin
            // Natural wrap through all-ones to zero handles descending ranges.
            cur_nonce <= cur_nonce + NONCE_W'(1);
         end
      end
   end

   // ----------------------------------------------------------------- counters
   hm_sat_counter #(.WIDTH(COUNT_W)) u_hash_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_ok),
      .inc   (job_done),
      .count (hash_count)
   );

   // Restarted for every job; only advances while waiting on the hasher.
   hm_sat_counter #(.WIDTH(TMO_W)) u_tmo_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == LAUNCH),
      .inc   ((state == WAIT) && !hash_done),
      .count (tmo_count)
   );

endmodule
